name_streamer: RTL and testbench
================================

# name_streamer

Character-stream transmitter for the name detector path. Holds a fixed name (default "GAYATRI") and, on a start pulse, emits it one 8-bit character per accepted cycle under a valid/ready handshake. The name is repeated a programmable number of times, with optional filler characters between repetitions. It feeds the detector's 8-bit character input and provides on-chip stimulus in place of a hand-written character sequence.

## Interface
- NAME_LEN, 7, number of characters in the name (1..16)
- NAME, "GAYATRI", name string, 8*NAME_LEN bits, ASCII uppercase, first character in the most significant byte
- GAP, 0, filler characters inserted between consecutive repetitions (0..15)
- FILL, 8'h58 ('X'), filler character code
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a transmission; sampled only in IDLE
- reps  input  4  repetition count; latched when start is accepted
- abort  input  1  synchronous cancel; returns to IDLE
- out_ready  input  1  sink accepts out_char this cycle
- out_char  output  8  current character; 8'h00 when not valid
- out_valid  output  1  out_char is a character to be transferred
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the final character is accepted

## Operation
- All outputs are registered. Reset (rst=0) forces out_char=8'h00, out_valid=0, busy=0, done=0, state=IDLE, and character index, repetition counter and gap counter to 0. Reset takes effect immediately, including mid-stream.
- Transfer: a character is accepted on a rising edge where out_valid=1 and out_ready=1. out_ready while out_valid=0 has no effect.
- Character k of the name (k=0 first) is NAME[8*(NAME_LEN-1-k) +: 8].
- States:
  - IDLE: out_valid=0, out_char=0. If start=1 and abort=0: latch reps into rem_reps. If reps=0, go to DONE. Otherwise go to SEND with index=0.
  - SEND: out_valid=1, out_char=name[index]. On accept with index<NAME_LEN-1, increment index. On accept of the last character, decrement rem_reps, then:
    - if rem_reps was 1, go to DONE;
    - else if GAP>0, go to GAP with gap count=0;
    - else set index=0 and stay in SEND.
  - GAP: out_valid=1, out_char=FILL. On each accept, increment the gap count. After the GAP-th accept, go to SEND with index=0.
  - DONE: out_valid=0, done=1 for exactly one cycle, busy=1. Then go to IDLE.
- abort=1 in any state returns to IDLE on the next edge, with out_valid=0 and no done pulse. If abort and start are both high in IDLE, abort wins.
- start outside IDLE is ignored. reps is only sampled at start acceptance.
- Holding: while out_valid=1 and out_ready=0, out_char, the state and all counters hold.
- Characters transferred for reps=R: R*NAME_LEN name characters plus (R-1)*GAP filler characters.

## Timing
- start accepted at edge E0: out_valid=1 with name[0] during the cycle after E0, so the first character is available one cycle after start.
- With out_ready held high, one character is transferred per cycle, with no bubbles between characters, repetitions or gaps.
- Last character accepted at edge En: done=1 and out_valid=0 in the cycle after En. busy falls one cycle later, and IDLE accepts a new start in that cycle.
- reps=0: done pulses in the cycle after start is accepted; out_valid is never asserted.
- The counters are sized for NAME_LEN up to 16, GAP up to 15 and reps up to 15, so no counter wraps within a legal configuration.

## Test plan
- Reset: assert rst=0 mid-stream with out_valid=1 -> out_valid=0, out_char=00, busy=0, done=0 immediately, without waiting for a clock edge. After release, the block is idle until start.
- Single name: reps=1, out_ready=1, start pulse -> out_char sequence 47,41,59,41,54,52,49 ("GAYATRI") on 7 consecutive cycles starting one cycle after start. done pulses the next cycle; busy is low the cycle after that.
- Repetition with gap: GAP=2 instance, reps=2 -> "GAYATRIXXGAYATRI", 16 consecutive valid cycles, then a single done pulse.
- Backpressure: reps=1, out_ready low for 3 cycles while out_char=59 ('Y') -> 'Y' is held stable with out_valid=1, then the sequence resumes with 41 ('A'). done arrives 3 cycles later than in the no-stall case.
- Abort: abort while presenting 'T' -> out_valid=0 on the next cycle, no done pulse, busy=0. A new start then restarts the sequence from 'G'.
- Edge cases: a start pulse while busy does not change the sequence. reps=0 -> done one cycle after start and no valid. start and abort together in IDLE -> remains IDLE.

Source files
------------

// File: rtl/name_streamer.sv
// Transmits a fixed name string under a valid/ready handshake. The name is
// repeated a latched number of times, with optional filler characters between repetitions.
module name_streamer #(
  parameter int                    NAME_LEN = 7,
  parameter logic [8*NAME_LEN-1:0] NAME     = "GAYATRI",
  parameter int                    GAP      = 0,
  parameter logic [7:0]            FILL     = 8'h58
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_reps,
  input  logic       i_abort,
  input  logic       i_out_ready,
  output logic [7:0] o_out_char,
  output logic       o_out_valid,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NAME_LEN - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t     r_state, w_state_next;
  logic [3:0] r_index, w_index_next;
  logic [3:0] r_rem_reps, w_rem_reps_next;
  logic [3:0] r_gap_cnt, w_gap_cnt_next;
  logic [7:0] w_char_next;
  logic       w_valid_next, w_busy_next, w_done_next;
  logic       w_accept;
  logic [7:0] w_name_chars [16];

  // Full 16-entry table so the 4-bit index always addresses a defined entry.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_chars
      if (gi < NAME_LEN) begin : g_used
        assign w_name_chars[gi] = NAME[8*(NAME_LEN-1-gi) +: 8];
      end else begin : g_unused
        assign w_name_chars[gi] = 8'h00;
      end
    end
  endgenerate

  assign w_accept = o_out_valid & i_out_ready;

  always_comb begin
    w_state_next    = r_state;
    w_index_next    = r_index;
    w_rem_reps_next = r_rem_reps;
    w_gap_cnt_next  = r_gap_cnt;
    if (i_abort) begin
      w_state_next    = ST_IDLE;
      w_index_next    = 4'd0;
      w_rem_reps_next = 4'd0;
      w_gap_cnt_next  = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_rem_reps_next = i_reps;
            w_index_next    = 4'd0;
            w_state_next    = (i_reps == 4'd0) ? ST_DONE : ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            if (r_index == LAST_IDX) begin
              w_rem_reps_next = r_rem_reps - 4'd1;
              w_index_next    = 4'd0;
              if (r_rem_reps == 4'd1) begin
                w_state_next = ST_DONE;
              end else if (GAP > 0) begin
                w_state_next   = ST_GAP;
                w_gap_cnt_next = 4'd0;
              end
            end else begin
              w_index_next = r_index + 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (w_accept) begin
            if (r_gap_cnt == GAP_LAST) begin
              w_state_next   = ST_SEND;
              w_index_next   = 4'd0;
              w_gap_cnt_next = 4'd0;
            end else begin
              w_gap_cnt_next = r_gap_cnt + 4'd1;
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they can be registered without a lag cycle.
  always_comb begin
    w_valid_next = (w_state_next == ST_SEND) || (w_state_next == ST_GAP);
    w_busy_next  = (w_state_next != ST_IDLE);
    w_done_next  = (w_state_next == ST_DONE);
    w_char_next  = 8'h00;
    if (w_state_next == ST_SEND) begin
      w_char_next = w_name_chars[w_index_next];
    end else if (w_state_next == ST_GAP) begin
      w_char_next = FILL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_index     <= 4'd0;
      r_rem_reps  <= 4'd0;
      r_gap_cnt   <= 4'd0;
      o_out_char  <= 8'h00;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_index     <= w_index_next;
      r_rem_reps  <= w_rem_reps_next;
      r_gap_cnt   <= w_gap_cnt_next;
      o_out_char  <= w_char_next;
      o_out_valid <= w_valid_next;
      o_busy      <= w_busy_next;
      o_done      <= w_done_next;
    end
  end

endmodule

// File: tb/tb_name_streamer.sv
// Bench for name_streamer: a GAP=0 and a GAP=2 instance share stimulus and are
// checked every cycle against a position/length stream model plus literal sequences.
module tb_name_streamer;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, out_ready;
  logic [3:0] reps;
  logic [7:0] ch0, ch2;
  logic       v0, v2, b0, b2, dn0, dn2;

  always #5 clk = ~clk;

  name_streamer dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_reps(reps), .i_abort(abort),
    .i_out_ready(out_ready), .o_out_char(ch0), .o_out_valid(v0), .o_busy(b0), .o_done(dn0)
  );

  name_streamer #(.GAP(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_reps(reps), .i_abort(abort),
    .i_out_ready(out_ready), .o_out_char(ch2), .o_out_valid(v2), .o_busy(b2), .o_done(dn2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0;

  // Model: a transmission is a stream of m_len characters; m_pos is the next one to send.
  int m_busy [2];
  int m_done [2];
  int m_pos  [2];
  int m_len  [2];
  logic [7:0] name_b [7] = '{8'h47, 8'h41, 8'h59, 8'h41, 8'h54, 8'h52, 8'h49};

  logic [7:0] cap0[$];
  logic [7:0] cap2[$];
  int done_at [2];
  int done_seen [2];
  int valid_seen [2];

  string lit_name = "GAYATRI";
  string lit_gap  = "GAYATRIXXGAYATRI";

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] char_at(input int p, input int g);
    int r;
    r = p % (7 + g);
    return (r < 7) ? name_b[r] : 8'h58;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_pos[i] = 0; m_len[i] = 0;
    end
  endtask

  task automatic model_step();
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || abort) begin
        m_busy[i] = 0; m_done[i] = 0; m_pos[i] = 0; m_len[i] = 0;
      end else if (m_done[i] != 0) begin
        m_done[i] = 0; m_busy[i] = 0;
      end else if (m_busy[i] == 0) begin
        if (start) begin
          m_busy[i] = 1;
          m_pos[i]  = 0;
          m_len[i]  = (reps == 4'd0) ? 0 : int'(reps) * 7 + (int'(reps) - 1) * 2 * i;
          if (m_len[i] == 0) m_done[i] = 1;
        end
      end else if (out_ready) begin
        m_pos[i]++;
        if (m_pos[i] == m_len[i]) m_done[i] = 1;
      end
    end
  endtask

  task automatic compare();
    int ev, ec;
    logic [7:0] dc;
    logic dv, db, dd;
    for (int i = 0; i < 2; i++) begin
      dc = (i == 0) ? ch0 : ch2;
      dv = (i == 0) ? v0 : v2;
      db = (i == 0) ? b0 : b2;
      dd = (i == 0) ? dn0 : dn2;
      ev = (m_busy[i] != 0 && m_done[i] == 0) ? 1 : 0;
      ec = (ev != 0) ? int'(char_at(m_pos[i], 2 * i)) : 0;
      chk((i == 0) ? "valid_g0" : "valid_g2", int'(dv), ev);
      chk((i == 0) ? "char_g0" : "char_g2", int'(dc), ec);
      chk((i == 0) ? "busy_g0" : "busy_g2", int'(db), m_busy[i]);
      chk((i == 0) ? "done_g0" : "done_g2", int'(dd), m_done[i]);
      if (dv) valid_seen[i] = 1;
      if (dd) begin
        done_seen[i] = 1;
        done_at[i] = cyc;
      end
    end
    if (v0 && out_ready) cap0.push_back(ch0);
    if (v2 && out_ready) cap2.push_back(ch2);
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic clear_obs();
    cap0.delete();
    cap2.delete();
    for (int i = 0; i < 2; i++) begin
      done_at[i] = -1; done_seen[i] = 0; valid_seen[i] = 0;
    end
  endtask

  task automatic pulse_start(input logic [3:0] r);
    reps = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    c0 = cyc;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; reps = 4'd0;
    model_reset();
    clear_obs();
    #1;
    chk("reset_valid", int'(v0), 0);
    chk("reset_busy", int'(b0), 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(3);

    // Single name, no stall
    clear_obs();
    pulse_start(4'd1);
    ticks(10);
    chk("single_len", cap0.size(), 7);
    for (int k = 0; k < 7 && k < cap0.size(); k++) chk("single_char", int'(cap0[k]), int'(lit_name[k]));
    chk("single_done_at", done_at[0], c0 + 7);
    $display("single name: %0d chars, done at +%0d", cap0.size(), done_at[0] - c0);

    // Two repetitions: GAP=2 instance inserts two fillers
    clear_obs();
    pulse_start(4'd2);
    ticks(20);
    chk("gap_len", cap2.size(), 16);
    for (int k = 0; k < 16 && k < cap2.size(); k++) chk("gap_char", int'(cap2[k]), int'(lit_gap[k]));
    chk("gap_done_at", done_at[1], c0 + 16);
    chk("nogap_done_at", done_at[0], c0 + 14);
    $display("repetition: gap2 %0d chars, gap0 %0d chars", cap2.size(), cap0.size());

    // Backpressure on 'Y'
    clear_obs();
    pulse_start(4'd1);
    ticks(2);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_char", int'(ch0), 8'h59);
      chk("stall_valid", int'(v0), 1);
    end
    out_ready = 1'b1;
    ticks(10);
    chk("bp_len", cap0.size(), 7);
    if (cap0.size() > 3) chk("bp_resume", int'(cap0[3]), 8'h41);
    chk("bp_done_at", done_at[0], c0 + 10);
    $display("backpressure: done at +%0d", done_at[0] - c0);

    // Abort on 'T', then restart
    clear_obs();
    pulse_start(4'd1);
    ticks(4);
    chk("pre_abort_char", int'(ch0), 8'h54);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", int'(v0), 0);
    chk("abort_busy", int'(b0), 0);
    ticks(5);
    chk("abort_no_done", done_seen[0], 0);
    clear_obs();
    pulse_start(4'd1);
    ticks(10);
    chk("restart_len", cap0.size(), 7);
    if (cap0.size() > 0) chk("restart_first", int'(cap0[0]), 8'h47);
    $display("abort: restart produced %0d chars", cap0.size());

    // Start while busy is ignored
    clear_obs();
    pulse_start(4'd1);
    ticks(2);
    reps = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(8);
    chk("busy_start_len", cap0.size(), 7);
    chk("busy_start_done", done_at[0], c0 + 7);
    $display("start while busy: %0d chars", cap0.size());

    // reps=0
    clear_obs();
    pulse_start(4'd0);
    ticks(3);
    chk("reps0_done_at", done_at[0], c0);
    chk("reps0_no_valid", valid_seen[0] + valid_seen[1], 0);
    $display("reps=0: done at +%0d", done_at[0] - c0);

    // start and abort together
    clear_obs();
    reps = 4'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", int'(b0), 0);
    ticks(3);
    chk("start_abort_no_valid", valid_seen[0], 0);
    $display("start+abort: stayed idle");

    // Mid-stream asynchronous reset
    pulse_start(4'd3);
    ticks(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(v0), 0);
    chk("async_rst_char", int'(ch0), 0);
    chk("async_rst_busy", int'(b2), 0);
    model_reset();
    ticks(2);
    rst_n = 1'b1;
    ticks(3);
    $display("async reset: outputs cleared");

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      start     = ($urandom_range(0, 7) == 0);
      reps      = 4'($urandom_range(0, 4));
      abort     = ($urandom_range(0, 79) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    ticks(40);
    $display("random: completed");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
